// File: rtl/ddr3_rw_pkg.sv
`default_nettype none
// ============================================================================
// Module : ddr3_rw_pkg
// Brief  : Shared constants and burst FSM encoding for the DDR3 AXI movers.
// Rev    : 1.0 - initial release
// ============================================================================
package ddr3_rw_pkg;

    localparam int AXI_ADDR_WIDTH = 28;
    localparam int DATA_WIDTH     = 128;
    localparam int BURST_LEN      = 16;
    localparam int BURST_BYTES    = BURST_LEN * DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } burst_state_e;

    // Plain-vector view of the encoding for controllers that keep a logic state register
    localparam logic [1:0] c_ST_IDLE = ST_IDLE;
    localparam logic [1:0] c_ST_AW   = ST_AW;
    localparam logic [1:0] c_ST_W    = ST_W;
    localparam logic [1:0] c_ST_B    = ST_B;

endpackage
`default_nettype wire

// File: rtl/fifo_skid_buf2.sv
`default_nettype none
// ============================================================================
// Module : fifo_skid_buf2
// Brief  : Two-entry data buffer with simultaneous push/pop and head output.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_skid_buf2 #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [1:0]            o_occ,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_head
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_occ;
    logic                  w_pop_ok;
    logic                  w_push_ok;

    // Guard both sides so a misbehaving caller cannot corrupt the occupancy count
    assign w_pop_ok  = i_pop && (r_occ != 2'd0);
    assign w_push_ok = i_push && ((r_occ != 2'd2) || w_pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ   = r_occ;
    assign o_valid = (r_occ != 2'd0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/ddr3_wr_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ddr3_wr_burst_ctrl
// Brief  : Drains wr_fifo into fixed-length AXI4 INCR write bursts over a
//          circular address region.
// Rev    : 1.0 - initial release
// ============================================================================
module ddr3_wr_burst_ctrl #(
    parameter int                            AXI_ADDR_WIDTH = ddr3_rw_pkg::AXI_ADDR_WIDTH,
    parameter int                            DATA_WIDTH     = ddr3_rw_pkg::DATA_WIDTH,
    parameter int                            BURST_LEN      = ddr3_rw_pkg::BURST_LEN,
    parameter int                            WL_WIDTH       = 11,
    parameter logic [AXI_ADDR_WIDTH-1:0]     ADDR_BASE      = '0,
    parameter longint unsigned               ADDR_SPAN      = 64'd1048576
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_enable,
    input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
    output logic                      fifo_rd_en,
    input  logic                      fifo_rd_empty,
    input  logic [WL_WIDTH-1:0]       fifo_rd_water_level,
    output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
    output logic [7:0]                axi_awlen,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    output logic [DATA_WIDTH-1:0]     axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   axi_wstrb,
    output logic                      axi_wlast,
    output logic                      axi_wvalid,
    input  logic                      axi_wready,
    input  logic [1:0]                axi_bresp,
    input  logic                      axi_bvalid,
    output logic                      axi_bready,
    output logic                      burst_done,
    output logic                      resp_err
);

    import ddr3_rw_pkg::c_ST_IDLE;
    import ddr3_rw_pkg::c_ST_AW;
    import ddr3_rw_pkg::c_ST_W;
    import ddr3_rw_pkg::c_ST_B;

    localparam int                  c_CNT_W     = $clog2(BURST_LEN + 1);
    localparam logic [AXI_ADDR_WIDTH:0] c_BURST_INC = (AXI_ADDR_WIDTH+1)'(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [AXI_ADDR_WIDTH:0] c_ADDR_END  = {1'b0, ADDR_BASE} + (AXI_ADDR_WIDTH+1)'(ADDR_SPAN);

    logic [1:0]                r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [c_CNT_W-1:0]        r_fetch_cnt;
    logic [c_CNT_W-1:0]        r_beat_cnt;
    logic                      r_inflight;
    logic                      r_resp_err;

    logic [1:0]                w_occ;
    logic                      w_buf_valid;
    logic [DATA_WIDTH-1:0]     w_head;
    logic                      w_pop;
    logic                      w_active;
    logic [2:0]                w_slots;
    logic                      w_last_beat;
    logic                      w_w_done;
    logic                      w_start;
    logic [AXI_ADDR_WIDTH:0]   w_addr_sum;
    logic [AXI_ADDR_WIDTH-1:0] w_addr_next;

    fifo_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (fifo_rd_data),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_valid     (w_buf_valid),
        .o_head      (w_head)
    );

    assign w_pop       = w_buf_valid && axi_wready;
    assign w_active    = (r_state == c_ST_AW) || (r_state == c_ST_W);
    // Entries that will be held next cycle if nothing new is requested now
    assign w_slots     = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_rd_en  = w_active && (r_fetch_cnt < c_CNT_W'(BURST_LEN))
                         && !fifo_rd_empty && (w_slots < 3'd2);
    assign w_last_beat = (r_beat_cnt == c_CNT_W'(BURST_LEN - 1));
    assign w_w_done    = (r_beat_cnt == c_CNT_W'(BURST_LEN)) || (w_pop && w_last_beat);
    assign w_start     = wr_enable && (fifo_rd_water_level >= WL_WIDTH'(BURST_LEN));

    assign w_addr_sum  = {1'b0, r_addr} + c_BURST_INC;
    assign w_addr_next = (w_addr_sum == c_ADDR_END) ? ADDR_BASE : w_addr_sum[AXI_ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_addr      <= ADDR_BASE;
            r_fetch_cnt <= '0;
            r_beat_cnt  <= '0;
            r_inflight  <= 1'b0;
            r_resp_err  <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (fifo_rd_en) begin
                r_fetch_cnt <= r_fetch_cnt + c_CNT_W'(1);
            end
            if (w_pop) begin
                r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
            end
            case (r_state)
                c_ST_IDLE: begin
                    r_fetch_cnt <= '0;
                    r_beat_cnt  <= '0;
                    if (w_start) begin
                        r_state <= c_ST_AW;
                    end
                end
                c_ST_AW: begin
                    // Data may finish ahead of the address when awready is slow
                    if (axi_awready) begin
                        r_state <= w_w_done ? c_ST_B : c_ST_W;
                    end
                end
                c_ST_W: begin
                    if (w_pop && w_last_beat) begin
                        r_state <= c_ST_B;
                    end
                end
                c_ST_B: begin
                    if (axi_bvalid) begin
                        r_state <= c_ST_IDLE;
                        r_addr  <= w_addr_next;
                        if (axi_bresp != 2'b00) begin
                            r_resp_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign axi_awaddr  = r_addr;
    assign axi_awlen   = 8'(BURST_LEN - 1);
    assign axi_awvalid = (r_state == c_ST_AW);
    assign axi_wdata   = w_head;
    assign axi_wstrb   = '1;
    assign axi_wvalid  = w_buf_valid;
    assign axi_wlast   = w_buf_valid && w_last_beat;
    assign axi_bready  = (r_state == c_ST_B);
    assign burst_done  = (r_state == c_ST_B) && axi_bvalid;
    assign resp_err    = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_wr_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ddr3_wr_burst_ctrl
// Brief  : Directed self-checking bench for ddr3_wr_burst_ctrl with a FIFO model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ddr3_wr_burst_ctrl;

    localparam int AW   = 28;
    localparam int DW   = 128;
    localparam int BL   = 16;
    localparam int WL   = 11;
    localparam int SPAN = 1024;
    localparam int BYTES = BL * DW / 8;

    logic          clk = 1'b0;
    logic          tb_rst = 1'b1;
    logic          wr_enable = 1'b0;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_en;
    wire           fifo_rd_empty;
    wire  [WL-1:0] fifo_rd_water_level;
    logic [AW-1:0] axi_awaddr;
    logic [7:0]    axi_awlen;
    logic          axi_awvalid;
    logic          axi_awready = 1'b1;
    logic [DW-1:0] axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic          axi_wlast;
    logic          axi_wvalid;
    logic          axi_wready = 1'b1;
    logic [1:0]    axi_bresp = 2'b00;
    logic          axi_bvalid = 1'b1;
    logic          axi_bready;
    logic          burst_done;
    logic          resp_err;

    int n_vec = 0;
    int n_err = 0;
    int n_pushed = 0;
    int n_popped = 0;
    int m_exp_idx = 0;
    int m_exp_addr = 0;
    int m_beat = 0;
    int m_w_count = 0;
    int m_rd_count = 0;
    int m_done_count = 0;
    int err_burst = 3;
    logic wready_toggle = 1'b0;
    logic m_hold = 1'b0;
    logic [DW-1:0] m_held_data = '0;
    logic [1:0]    m_held_ctl = '0;

    ddr3_wr_burst_ctrl #(
        .AXI_ADDR_WIDTH (AW),
        .DATA_WIDTH     (DW),
        .BURST_LEN      (BL),
        .WL_WIDTH       (WL),
        .ADDR_BASE      ('0),
        .ADDR_SPAN      (64'(SPAN))
    ) dut (
        .clk                 (clk),
        .rst                 (tb_rst),
        .wr_enable           (wr_enable),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_rd_water_level (fifo_rd_water_level),
        .axi_awaddr          (axi_awaddr),
        .axi_awlen           (axi_awlen),
        .axi_awvalid         (axi_awvalid),
        .axi_awready         (axi_awready),
        .axi_wdata           (axi_wdata),
        .axi_wstrb           (axi_wstrb),
        .axi_wlast           (axi_wlast),
        .axi_wvalid          (axi_wvalid),
        .axi_wready          (axi_wready),
        .axi_bresp           (axi_bresp),
        .axi_bvalid          (axi_bvalid),
        .axi_bready          (axi_bready),
        .burst_done          (burst_done),
        .resp_err            (resp_err)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [DW-1:0] word_of(input int idx);
        logic [31:0] u;
        u = 32'(idx);
        return {~u, u ^ 32'hA5A5_A5A5, u + 32'h0000_0100, u};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model: word index i holds word_of(i); read data appears the cycle after rd_en
    always @(posedge clk) begin
        if (tb_rst) begin
            n_popped <= n_pushed;
        end else if (fifo_rd_en && (n_popped != n_pushed)) begin
            fifo_rd_data <= word_of(n_popped);
            n_popped     <= n_popped + 1;
        end
    end
    assign fifo_rd_water_level = WL'(n_pushed - n_popped);
    assign fifo_rd_empty       = (n_pushed == n_popped);

    initial begin
        forever begin
            @(posedge clk); #1;
            if (wready_toggle) axi_wready = ~axi_wready;
            axi_bresp = (m_done_count == err_burst) ? 2'd2 : 2'd0;
        end
    end

    // Handshake monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!tb_rst) begin
            if (m_hold) begin
                check("hold_wdata", 128'(axi_wdata), 128'(m_held_data));
                check("hold_ctl", 128'({axi_wvalid, axi_wlast}), 128'(m_held_ctl));
            end
            m_hold      = axi_wvalid && !axi_wready;
            m_held_data = axi_wdata;
            m_held_ctl  = {axi_wvalid, axi_wlast};
            if (fifo_rd_en) begin
                m_rd_count++;
                check("rd_not_empty", 128'(fifo_rd_empty), 128'(0));
            end
            if (axi_awvalid && axi_awready) begin
                check("awaddr", 128'(axi_awaddr), 128'(m_exp_addr));
                check("awlen", 128'(axi_awlen), 128'(BL - 1));
            end
            if (axi_wvalid && axi_wready) begin
                check("wdata", 128'(axi_wdata), 128'(word_of(m_exp_idx)));
                check("wlast", 128'(axi_wlast), 128'(m_beat == BL - 1));
                check("wstrb", 128'(axi_wstrb), {112'b0, 16'hFFFF});
                m_exp_idx++;
                m_w_count++;
                m_beat = (m_beat == BL - 1) ? 0 : m_beat + 1;
            end
            if (axi_bvalid && axi_bready) begin
                check("burst_done", 128'(burst_done), 128'(1));
                m_done_count++;
                m_exp_addr = (m_exp_addr + BYTES) % SPAN;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        tb_rst     = 1'b1;
        m_beat     = 0;
        m_exp_addr = 0;
        m_hold     = 1'b0;
        m_exp_idx  = n_pushed;
        @(posedge clk); #1;
        tb_rst = 1'b0;
    endtask

    task automatic push_now(input int n);
        @(posedge clk); #1;
        n_pushed += n;
    endtask

    task automatic push_stream(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            n_pushed++;
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int i;
        i = 0;
        while (m_done_count < target && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        check("done_count", 128'(m_done_count), 128'(target));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"}, 128'(fifo_rd_en), 128'(0));
        check({tag, "_awvalid"}, 128'(axi_awvalid), 128'(0));
        check({tag, "_wvalid"}, 128'(axi_wvalid), 128'(0));
        check({tag, "_wlast"}, 128'(axi_wlast), 128'(0));
        check({tag, "_bready"}, 128'(axi_bready), 128'(0));
        check({tag, "_bdone"}, 128'(burst_done), 128'(0));
        check({tag, "_resp_err"}, 128'(resp_err), 128'(0));
        check({tag, "_awaddr"}, 128'(axi_awaddr), 128'(0));
    endtask

    initial begin
        int w0;
        int r0;
        int cnt;
        do_reset();
        @(negedge clk);
        check_idle_outputs("rst");
        check("rst_wdata", 128'(axi_wdata), 128'(0));

        // Single burst with full-speed handshakes and start latency
        wr_enable = 1'b1;
        push_now(BL);
        @(negedge clk);
        check("lat_n_awvalid", 128'(axi_awvalid), 128'(0));
        @(negedge clk);
        check("lat_n1_awvalid", 128'(axi_awvalid), 128'(1));
        check("lat_n1_rd_en", 128'(fifo_rd_en), 128'(1));
        check("lat_n1_awaddr", 128'(axi_awaddr), 128'(0));
        @(negedge clk);
        check("lat_n2_wvalid", 128'(axi_wvalid), 128'(0));
        @(negedge clk);
        check("lat_n3_wvalid", 128'(axi_wvalid), 128'(1));
        check("lat_n3_wdata", 128'(axi_wdata), 128'(word_of(0)));
        wait_done(1, 60);
        check("b1_words", 128'(m_w_count), 128'(BL));
        check("b1_reads", 128'(m_rd_count), 128'(BL));

        // Level one short of a burst must not start
        push_now(BL - 1);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (axi_awvalid) cnt++;
        end
        check("lvl15_no_aw", 128'(cnt), 128'(0));
        push_now(1);
        cnt = 0;
        while (!axi_awvalid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("lvl16_start_le2", 128'(axi_awvalid && cnt <= 2), 128'(1));
        wait_done(2, 60);

        // Alternating wready
        @(negedge clk);
        wready_toggle = 1'b1;
        w0 = m_w_count;
        r0 = m_rd_count;
        push_now(BL);
        wait_done(3, 120);
        @(negedge clk);
        wready_toggle = 1'b0;
        axi_wready    = 1'b1;
        check("toggle_words", 128'(m_w_count - w0), 128'(BL));
        check("toggle_reads", 128'(m_rd_count - r0), 128'(BL));
        check("err_clear", 128'(resp_err), 128'(0));

        // SLVERR on burst 4, then streamed bursts across the wrap
        push_now(BL);
        wait_done(4, 60);
        @(negedge clk);
        check("err_set", 128'(resp_err), 128'(1));
        push_stream(6 * BL);
        wait_done(10, 200);
        @(negedge clk);
        check("err_sticky", 128'(resp_err), 128'(1));

        // Reset in the middle of the W phase
        w0 = m_w_count;
        push_now(BL);
        cnt = 0;
        while (m_w_count < w0 + 8 && cnt < 60) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("midw_reached", 128'(m_w_count >= w0 + 8), 128'(1));
        do_reset();
        @(negedge clk);
        check_idle_outputs("midw_rst");
        w0 = m_w_count;
        push_now(BL);
        wait_done(11, 60);
        check("post_rst_words", 128'(m_w_count - w0), 128'(BL));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
